// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the behavioural main-memory stage.
// Holds the FSM state encoding and the beats-per-block arithmetic used by the bus.
package main_mem_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WR_WAIT,
      RD_WAIT,
      RD_BURST
   } main_mem_state_e;

   // Beats per block read; also sizes the bus transaction counter.
   function automatic int unsigned mem_beats(input int unsigned block_w, input int unsigned dma_w);
      return block_w / dma_w;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/main_mem_sram_1r1w.sv
// Storage array for main_mem: one synchronous write port and one registered read port.
// Each entry is one DMA beat wide.
module mem_sram_1r1w #(
   parameter int unsigned width_p = 32,
   parameter int unsigned depth_p = 4096
) (
   input  logic                       clk_i,
   input  logic                       w_en_i,
   input  logic [$clog2(depth_p)-1:0] w_addr_i,
   input  logic [width_p-1:0]         w_data_i,
   input  logic                       r_en_i,
   input  logic [$clog2(depth_p)-1:0] r_addr_i,
   output logic [width_p-1:0]         r_data_o
);

   logic [width_p-1:0] mem [depth_p];
   logic [width_p-1:0] r_data_q;

   // NOTE: the array and its read register are deliberately never reset; contents are only
   // meaningful after a write, and a reset network on storage would be pure cost.
   always_ff @(posedge clk_i) begin
      if (w_en_i) begin
         mem[w_addr_i] <= w_data_i;
      end
      if (r_en_i) begin
         r_data_q <= mem[r_addr_i];
      end
   end

   assign r_data_o = r_data_q;

endmodule

// File: rtl/main_mem.sv
// Behavioural main memory behind the cache bus arbiter: single-beat writes and
// fixed-latency block reads, with ready held low for the whole busy window.
module main_mem
   import main_mem_pkg::*;
#(
   parameter int unsigned block_width_p    = 4,
   parameter int unsigned dma_data_width_p = 1,
   parameter int unsigned mem_words_p      = 4096,
   parameter int unsigned rd_latency_p     = 4,
   parameter int unsigned wr_latency_p     = 0
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               mem_valid_i,
   output logic                               mem_ready_o,
   input  logic                               mem_we_i,
   input  logic [31:0]                        mem_addr_i,
   input  logic [dma_data_width_p*WORD_W-1:0] mem_wdata_i,
   output logic                               mem_valid_o,
   output logic [dma_data_width_p*WORD_W-1:0] mem_data_o
);

   localparam int unsigned data_w_lp    = dma_data_width_p * WORD_W;
   localparam int unsigned ratio_lp     = mem_beats(block_width_p, dma_data_width_p);
   localparam int unsigned lines_lp     = mem_words_p / dma_data_width_p;
   localparam int unsigned line_w_lp    = $clog2(lines_lp);
   localparam int unsigned word_w_lp    = $clog2(mem_words_p);
   localparam int unsigned dma_shift_lp = $clog2(dma_data_width_p);
   localparam int unsigned beat_w_lp    = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
   localparam int unsigned max_lat_lp   = (rd_latency_p > wr_latency_p) ? rd_latency_p : wr_latency_p;
   localparam int unsigned cnt_w_lp     = $clog2(max_lat_lp + 1);
   localparam logic [line_w_lp-1:0] base_mask_lp = ~(line_w_lp'(ratio_lp - 1));

   if (!is_pow2(block_width_p) || !is_pow2(dma_data_width_p) || !is_pow2(mem_words_p)) begin : g_bad_pow2
      $error("main_mem: block_width_p, dma_data_width_p and mem_words_p must be powers of 2");
   end
   if (block_width_p < dma_data_width_p) begin : g_bad_block
      $error("main_mem: block_width_p must be >= dma_data_width_p");
   end
   if (rd_latency_p < 1) begin : g_bad_rd_lat
      $error("main_mem: rd_latency_p must be >= 1");
   end
   if (mem_words_p < 2 * block_width_p) begin : g_bad_depth
      $error("main_mem: mem_words_p must hold at least two blocks");
   end

   main_mem_state_e       state_q, state_d;
   logic [cnt_w_lp-1:0]   lat_cnt_q, lat_cnt_d;
   logic [beat_w_lp-1:0]  beat_q, beat_d;
   logic [line_w_lp-1:0]  base_q, base_d;

   logic                  wr_en;
   logic                  rd_en;
   logic [line_w_lp-1:0]  line_idx;
   logic [line_w_lp-1:0]  rd_addr;
   logic [data_w_lp-1:0]  rd_data;
   logic                  unused_addr_bits;

   // Word index wraps modulo the depth; low bits below a beat are masked off.
   assign line_idx         = mem_addr_i[word_w_lp+1:2+dma_shift_lp];
   assign unused_addr_bits = ^{mem_addr_i[31:word_w_lp+2], mem_addr_i[dma_shift_lp+1:0]};

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      beat_d    = beat_q;
      base_d    = base_q;
      wr_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_valid_i && mem_we_i) begin
               wr_en = !reset_i;
               if (wr_latency_p > 0) begin
                  state_d   = WR_WAIT;
                  lat_cnt_d = cnt_w_lp'(wr_latency_p);
               end
            end else if (mem_valid_i) begin
               base_d = line_idx & base_mask_lp;
               beat_d = '0;
               if (rd_latency_p == 1) begin
                  state_d = RD_BURST;
               end else begin
                  state_d   = RD_WAIT;
                  lat_cnt_d = cnt_w_lp'(rd_latency_p - 1);
               end
            end
         end
         WR_WAIT: begin
            lat_cnt_d = lat_cnt_q - cnt_w_lp'(1);
            if (lat_cnt_d == '0) begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            lat_cnt_d = lat_cnt_q - cnt_w_lp'(1);
            if (lat_cnt_d == '0) begin
               state_d = RD_BURST;
               beat_d  = '0;
            end
         end
         RD_BURST: begin
            if (beat_q == beat_w_lp'(ratio_lp - 1)) begin
               state_d = IDLE;
            end else begin
               beat_d = beat_q + beat_w_lp'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The array read is registered, so fetch the beat that will be presented next cycle.
   assign rd_en   = (state_d == RD_BURST);
   assign rd_addr = base_d | line_w_lp'(beat_d);

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         beat_q    <= '0;
         base_q    <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
      end
   end

   mem_sram_1r1w #(
      .width_p (data_w_lp),
      .depth_p (lines_lp)
   ) u_sram (
      .clk_i    (clk_i),
      .w_en_i   (wr_en),
      .w_addr_i (line_idx),
      .w_data_i (mem_wdata_i),
      .r_en_i   (rd_en),
      .r_addr_i (rd_addr),
      .r_data_o (rd_data)
   );

   assign mem_ready_o = (state_q == IDLE);
   assign mem_valid_o = (state_q == RD_BURST);
   assign mem_data_o  = mem_valid_o ? rd_data : '0;

endmodule

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem: default configuration plus a wide-beat,
// short-latency instance, both checked against a word-array reference model.
module tb_main_mem;

   localparam int RD_LAT = 4;
   localparam int RATIO  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_i;

   logic         a_valid_i, a_we_i;
   logic [31:0]  a_addr_i, a_wdata_i;
   logic         a_ready_o, a_valid_o;
   logic [31:0]  a_data_o;

   logic         b_valid_i, b_we_i;
   logic [31:0]  b_addr_i;
   logic [127:0] b_wdata_i;
   logic         b_ready_o, b_valid_o;
   logic [127:0] b_data_o;

   logic [31:0]  ref_a [0:4095];
   logic [127:0] ref_b [0:1023];

   int n_checks = 0;
   int n_pass   = 0;

   main_mem u_a (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .mem_valid_i (a_valid_i),
      .mem_ready_o (a_ready_o),
      .mem_we_i    (a_we_i),
      .mem_addr_i  (a_addr_i),
      .mem_wdata_i (a_wdata_i),
      .mem_valid_o (a_valid_o),
      .mem_data_o  (a_data_o)
   );

   main_mem #(
      .block_width_p    (4),
      .dma_data_width_p (4),
      .rd_latency_p     (1),
      .wr_latency_p     (2)
   ) u_b (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .mem_valid_i (b_valid_i),
      .mem_ready_o (b_ready_o),
      .mem_we_i    (b_we_i),
      .mem_addr_i  (b_addr_i),
      .mem_wdata_i (b_wdata_i),
      .mem_valid_o (b_valid_o),
      .mem_data_o  (b_data_o)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random byte address whose word index lies in 0..255, with random upper bits to exercise wrap.
   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      return r & 32'hFFFF_C3FF;
   endfunction

   task automatic a_write(input logic [31:0] addr, input logic [31:0] data);
      check("a_wr_ready_pre", a_ready_o, 1'b1);
      a_valid_i = 1'b1;
      a_we_i    = 1'b1;
      a_addr_i  = addr;
      a_wdata_i = data;
      tick();
      a_valid_i = 1'b0;
      a_we_i    = 1'b0;
      ref_a[addr[13:2]] = data;
      check("a_wr_ready_post", a_ready_o, 1'b1);
   endtask

   // Block read; with spam set, write requests are held on the bus throughout the busy window.
   task automatic a_read(input logic [31:0] addr, input bit spam);
      logic [11:0] base;
      base = {addr[13:4], 2'b00};
      check("a_rd_ready_pre", a_ready_o, 1'b1);
      a_valid_i = 1'b1;
      a_we_i    = 1'b0;
      a_addr_i  = addr;
      tick();
      if (spam) a_we_i = 1'b1;
      else a_valid_i = 1'b0;
      for (int i = 1; i <= RD_LAT + RATIO; i++) begin
         bit          in_burst;
         logic [11:0] widx;
         in_burst = (i >= RD_LAT) && (i < RD_LAT + RATIO);
         widx     = base + 12'(i - RD_LAT);
         check("a_rd_ready", a_ready_o, i == RD_LAT + RATIO);
         check("a_rd_valid", a_valid_o, in_burst);
         check("a_rd_data", a_data_o, in_burst ? ref_a[widx] : 32'h0);
         if (i == RD_LAT + RATIO) begin
            a_valid_i = 1'b0;
         end else begin
            if (spam) begin
               a_addr_i  = rand_addr();
               a_wdata_i = $urandom;
            end
            tick();
         end
      end
      a_we_i = 1'b0;
   endtask

   task automatic b_write(input logic [31:0] addr, input logic [127:0] data);
      check("b_wr_ready_pre", b_ready_o, 1'b1);
      b_valid_i = 1'b1;
      b_we_i    = 1'b1;
      b_addr_i  = addr;
      b_wdata_i = data;
      tick();
      b_valid_i = 1'b0;
      b_we_i    = 1'b0;
      ref_b[addr[13:4]] = data;
      check("b_wr_busy1", b_ready_o, 1'b0);
      tick();
      check("b_wr_busy2", b_ready_o, 1'b0);
      tick();
      check("b_wr_ready_back", b_ready_o, 1'b1);
   endtask

   task automatic b_read(input logic [31:0] addr);
      check("b_rd_ready_pre", b_ready_o, 1'b1);
      b_valid_i = 1'b1;
      b_we_i    = 1'b0;
      b_addr_i  = addr;
      tick();
      b_valid_i = 1'b0;
      check("b_rd_valid", b_valid_o, 1'b1);
      check("b_rd_data", b_data_o, ref_b[addr[13:4]]);
      check("b_rd_busy", b_ready_o, 1'b0);
      tick();
      check("b_rd_valid_end", b_valid_o, 1'b0);
      check("b_rd_ready_back", b_ready_o, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0]  addr;
      logic [31:0]  b_addrs [8];
      logic [127:0] wide;

      // Reset held for 3 cycles with requests asserted on both buses.
      reset_i   = 1'b1;
      a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 32'h0; a_wdata_i = 32'h0;
      b_valid_i = 1'b1; b_we_i = 1'b0; b_addr_i = 32'h0; b_wdata_i = 128'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_a_ready", a_ready_o, 1'b1);
         check("rst_a_valid", a_valid_o, 1'b0);
         check("rst_a_data", a_data_o, 32'h0);
         check("rst_b_ready", b_ready_o, 1'b1);
         check("rst_b_valid", b_valid_o, 1'b0);
      end
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      reset_i   = 1'b0;
      tick();
      check("post_rst_a_ready", a_ready_o, 1'b1);
      check("post_rst_a_valid", a_valid_o, 1'b0);

      // Preload word indices 0..255 through back-to-back writes.
      for (int w = 0; w < 256; w++) begin
         addr = $urandom;
         addr = (addr & 32'hFFFF_C000) | 32'(w << 2);
         a_write(addr, $urandom);
      end

      // Write then read the same block.
      a_write(32'h0000_0040, 32'hDEAD_BEEF);
      a_read(32'h0000_0040, 1'b0);
      check("beat0_deadbeef", ref_a[16], 32'hDEAD_BEEF);

      // Unaligned read address returns the enclosing block in order.
      a_read(32'h0000_004C, 1'b0);

      // Writes presented during a burst must be ignored; sweep the whole region afterwards.
      a_read(rand_addr(), 1'b1);
      for (int blk = 0; blk < 64; blk++) begin
         a_read(32'(blk * 16), 1'b0);
      end

      // Reset after beat 1 of a burst.
      check("mid_rst_ready_pre", a_ready_o, 1'b1);
      a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 32'h0000_0080;
      tick();
      a_valid_i = 1'b0;
      for (int i = 0; i < RD_LAT; i++) tick();
      check("mid_rst_beat1_valid", a_valid_o, 1'b1);
      check("mid_rst_beat1_data", a_data_o, ref_a[33]);
      reset_i = 1'b1;
      #1;
      check("mid_rst_valid_drop", a_valid_o, 1'b0);
      check("mid_rst_data_zero", a_data_o, 32'h0);
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      check("mid_rst_ready_after", a_ready_o, 1'b1);
      check("mid_rst_valid_after", a_valid_o, 1'b0);
      a_read(32'h0000_0080, 1'b0);

      // Randomized mix of writes and reads.
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 0) a_write(rand_addr(), $urandom);
         else a_read(rand_addr(), $urandom_range(0, 3) == 0);
      end

      // Wide-beat instance: single 128-bit beat reads, two-cycle write busy window.
      for (int k = 0; k < 8; k++) begin
         b_addrs[k] = rand_addr();
         wide = {$urandom, $urandom, $urandom, $urandom};
         b_write(b_addrs[k], wide);
      end
      for (int k = 0; k < 8; k++) begin
         b_read(b_addrs[k]);
      end
      b_write(32'h0000_0048, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      b_read(32'h0000_0040);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
